data_mem_ctrl: RTL and testbench

Load/store unit between the single-cycle RISC-V core's data port and a word-wide, variable-latency data SRAM. It consumes the core's load/store enables, effective address (ALU result), store data (rs2 value) and funct3, and returns the load value on data_m. While an access is in flight it holds the core via cpu_stall. The SRAM has no byte enables, so SB/SH are done as read-modify-write.

---
 rtl/data_mem_ctrl_pkg.sv | 32 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/data_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// controller states and request-legality helpers.
package data_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } state_e;

    // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal for them.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3[2] || (f3[1:0] == 2'b11);
        end
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: extracts and extends load data from an SRAM
// word, and merges a byte/half store into an SRAM word for read-modify-write.
module lsu_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{byte_off, 3'b000} +: 8];
        sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            default: load_data = rdata;
        endcase

        // Word stores bypass the merge and take the full store operand.
        store_word = rdata;
        case (funct3[1:0])
            2'b00: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (byte_off[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit between the core data port and a word-wide, variable-latency
// SRAM without byte enables; sub-word stores are done as read-modify-write.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter bit ZERO_ON_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_fetch_data,
    input  logic              en_store_data,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    output logic [31:0]       data_m,
    output logic              cpu_stall,
    output logic              access_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       data_m_q, data_m_d;
    logic              err_q, err_d;

    logic              req;
    logic              req_err;
    logic [31:0]       load_val;
    logic [31:0]       merged_word;
    logic              unused_addr_hi;

    // Address bits beyond the SRAM are dropped, so accesses wrap.
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign req     = en_fetch_data | en_store_data;
    assign req_err = (en_fetch_data & en_store_data)
                   | f3_illegal(en_store_data, funct3)
                   | is_misaligned(funct3, addr[1:0]);

    lsu_align u_align (
        .funct3     (funct3_q),
        .byte_off   (off_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_val),
        .store_word (merged_word)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        mem_wdata_d = mem_wdata_q;
        data_m_d    = data_m_q;
        err_d       = 1'b0;
        cpu_stall   = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_err) begin
                        err_d = 1'b1;
                        if (en_fetch_data) begin
                            data_m_d = '0;
                        end
                    end else begin
                        cpu_stall  = 1'b1;
                        mem_addr_d = addr[ADDR_W+1:2];
                        off_d      = addr[1:0];
                        funct3_d   = funct3;
                        wdata_d    = wdata;
                        if (en_fetch_data) begin
                            state_d = ST_RD;
                        end else if (funct3 == F3_W) begin
                            mem_wdata_d = wdata;
                            state_d     = ST_WR;
                        end else begin
                            state_d = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                cpu_stall = 1'b1;
                mem_re    = 1'b1;
                if (mem_ready) begin
                    data_m_d = load_val;
                    state_d  = ST_DONE;
                end
            end
            ST_RMW_RD: begin
                cpu_stall = 1'b1;
                mem_re    = 1'b1;
                if (mem_ready) begin
                    mem_wdata_d = merged_word;
                    state_d     = ST_RMW_WR;
                end
            end
            ST_WR, ST_RMW_WR: begin
                cpu_stall = 1'b1;
                mem_we    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Core retires on this edge; the load value is only presented here.
                state_d = ST_IDLE;
                if (ZERO_ON_IDLE) begin
                    data_m_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            data_m_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            mem_wdata_q <= mem_wdata_d;
            data_m_q    <= data_m_d;
            err_q       <= err_d;
        end
    end

    assign data_m     = data_m_q;
    assign access_err = err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl with a behavioural SRAM and a word-array
// reference model of the load/store rules.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_fetch_data = 1'b0;
    logic        en_store_data = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] data_m;
    logic        cpu_stall;
    logic        access_err;
    logic [11:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(.ADDR_W(12), .ZERO_ON_IDLE(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_fetch_data (en_fetch_data),
        .en_store_data (en_store_data),
        .addr          (addr),
        .wdata         (wdata),
        .funct3        (funct3),
        .data_m        (data_m),
        .cpu_stall     (cpu_stall),
        .access_err    (access_err),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural SRAM; ref_mem is the architectural memory the model predicts.
    logic [31:0] sram    [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        sync_req = 1'b0;
    int          lat_fixed = 0;
    int          lat_rand = 0;
    int          wait_cnt = 0;

    assign mem_rdata = sram[mem_addr];
    assign mem_ready = (mem_re || mem_we) &&
                       (wait_cnt >= ((lat_fixed >= 0) ? lat_fixed : lat_rand));

    always @(posedge clk or posedge rst) begin
        if (sync_req) begin
            for (int i = 0; i < 4096; i++) sram[i] <= ref_mem[i];
        end
        if (rst) begin
            wait_cnt <= 0;
        end else if (mem_ready) begin
            wait_cnt <= 0;
            lat_rand <= $urandom_range(3);
            if (mem_we) sram[mem_addr] <= mem_wdata;
        end else if (mem_re || mem_we) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Protocol monitor: exclusive strobes, strobe and address held until ready.
    logic        prev_pending = 1'b0;
    logic [31:0] prev_snap = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_pending = 1'b0;
        end else begin
            check_eq("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
            if (prev_pending) check_eq("strobe_hold", {18'd0, mem_re, mem_we, mem_addr}, prev_snap);
            prev_pending = (mem_re || mem_we) && !mem_ready;
            prev_snap    = {18'd0, mem_re, mem_we, mem_addr};
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        sync_req = 1'b1;
        @(posedge clk);
        #1 sync_req = 1'b0;
    endtask

    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int          idx, off, nb, phases, cyc;
        logic        legal, err;
        logic [31:0] word, expv;
        longint      v;
        idx   = int'(a[13:2]);
        off   = int'(a[1:0]);
        nb    = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = (ld && st) || !legal || ((a % nb) != 0);
        phases = (ld || f3 == F3_W) ? 1 : 2;

        @(posedge clk);
        #1;
        en_fetch_data = ld;
        en_store_data = st;
        addr   = a;
        wdata  = wd;
        funct3 = f3;
        @(negedge clk);
        check_eq("idle_data_m", data_m, 32'd0);
        check_eq("idle_err", {31'd0, access_err}, 32'd0);
        check_eq("req_stall", {31'd0, cpu_stall}, {31'd0, !err});
        @(posedge clk);
        #1;
        en_fetch_data = 1'b0;
        en_store_data = 1'b0;
        addr   = $urandom;
        wdata  = $urandom;
        funct3 = 3'($urandom);
        if (err) begin
            @(negedge clk);
            check_eq("err_pulse", {31'd0, access_err}, 32'd1);
            check_eq("err_stall", {31'd0, cpu_stall}, 32'd0);
            check_eq("err_data_m", data_m, 32'd0);
            check_eq("err_no_strobe", {30'd0, mem_re, mem_we}, 32'd0);
            return;
        end

        cyc = 1;
        @(negedge clk);
        while (cpu_stall && cyc < 200) begin
            if (mem_re || mem_we) check_eq("mem_addr", {20'd0, mem_addr}, 32'(idx));
            cyc++;
            @(negedge clk);
        end
        if (cpu_stall) begin
            check_eq("stall_timeout", {31'd0, cpu_stall}, 32'd0);
            return;
        end
        if (lat_fixed >= 0) check_eq("stall_cycles", 32'(cyc), 32'(1 + phases * (lat_fixed + 1)));

        word = ref_mem[idx];
        if (ld) begin
            v = longint'(word >> (8 * off)) % (longint'(1) << (8 * nb));
            if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            expv = 32'(v);
            check_eq("load_data", data_m, expv);
        end else begin
            for (int k = 0; k < nb; k++) word[8 * (off + k) +: 8] = wd[8 * k +: 8];
            ref_mem[idx] = word;
            check_eq("store_word", sram[idx], word);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [2:0]  ld_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [31:0] a;
        logic        ld, st;
        int          r;

        for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
        sync_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 sync_req = 1'b0;
        check_eq("rst_data_m", data_m, 32'd0);
        check_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("rst_err", {31'd0, access_err}, 32'd0);
        check_eq("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        check_eq("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        lat_fixed = 0;
        preload(1, 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, F3_W, 32'h104, 32'h0);
        preload(32'h40, 32'h80FF7F01);
        do_txn(1'b1, 1'b0, F3_B, 32'h103, 32'h0);
        check_eq("lb_sign", data_m, 32'hFFFFFF80);
        do_txn(1'b1, 1'b0, F3_BU, 32'h103, 32'h0);
        check_eq("lbu_zero", data_m, 32'h00000080);
        preload(32'h80, 32'h11223344);
        do_txn(1'b0, 1'b1, F3_B, 32'h202, 32'h000000AA);
        check_eq("sb_merge", sram[32'h80], 32'h11AA3344);

        lat_fixed = 4;
        preload(1, 32'h89ABCDEF);
        do_txn(1'b0, 1'b1, F3_H, 32'h006, 32'h00005A5A);
        check_eq("sh_upper", sram[1], 32'h5A5ACDEF);

        lat_fixed = 0;
        do_txn(1'b1, 1'b0, F3_W, 32'h102, 32'h0);
        do_txn(1'b1, 1'b1, F3_W, 32'h100, 32'h0);

        // Reset while the RMW write strobe waits for the SRAM.
        lat_fixed = 4;
        preload(32'hC0, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        en_store_data = 1'b1;
        funct3 = F3_B;
        addr   = 32'h301;
        wdata  = 32'h55;
        @(posedge clk);
        #1 en_store_data = 1'b0;
        cyc = 0;
        while (!mem_we && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rmw_wr_reached", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mid_re", {31'd0, mem_re}, 32'd0);
        check_eq("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("rst_mid_data_m", data_m, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        check_eq("no_partial_write", sram[32'hC0], ref_mem[32'hC0]);
        lat_fixed = 0;
        do_txn(1'b0, 1'b1, F3_W, 32'h300, 32'h13572468);
        do_txn(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
        check_eq("sw_after_rst", data_m, 32'h13572468);

        for (int n = 0; n < 300; n++) begin
            lat_fixed = (n < 150) ? -1 : 0;
            r  = $urandom_range(99);
            ld = (r < 45) || (r >= 94);
            st = (r >= 45);
            if ($urandom_range(9) == 0) f3 = 3'($urandom);
            else if (ld && !st)         f3 = ld_tab[$urandom_range(4)];
            else                        f3 = 3'($urandom_range(2));
            a = $urandom;
            if ($urandom_range(3) != 0) a = a & ~(32'(1 << f3[1:0]) - 32'd1);
            do_txn(ld, st, f3, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
